// File: rtl/ibex_rf_wr_arbiter_if.sv
// Register-file write-port bundle: two requesters (A, B) and the shared write port.
interface ibex_rf_wr_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 req_a;
  logic [4:0]           addr_a;
  logic [DataWidth-1:0] data_a;
  logic                 gnt_a;
  logic                 req_b;
  logic [4:0]           addr_b;
  logic [DataWidth-1:0] data_b;
  logic                 gnt_b;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 rf_we;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  gnt_a, gnt_b, rf_waddr, rf_wdata, rf_we
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output gnt_a, gnt_b, rf_waddr, rf_wdata, rf_we
  );
endinterface

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter with boot/on-demand zero sweep, A>B priority.
// Optional B anti-starvation promotion enabled by defining IBEX_RF_ARB_FAIRNESS_EN.
module ibex_rf_wr_arbiter #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          StarveLimit = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     init_req_i,
  output logic                     init_busy_o,
  output logic                     err_o,
  ibex_rf_wr_arbiter_if.slave      bus
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastIdx  = 5'(NumWords - 1);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StInit = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  if (StarveLimit == 0) begin : g_bad_starve_limit
    $error("StarveLimit must be at least 1");
  end

  logic [1:0]           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 err_d;
  logic                 promote;
  logic                 sel_b;
  logic                 illegal;
  logic [4:0]           sel_addr;
  logic                 gnt_a, gnt_b, rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;

  // State, sweep counter and error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StBoot;
      cnt_q   <= 5'd1;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_o   <= err_d;
    end
  end

  // Next state, sweep sequencing and same-cycle arbitration
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    init_busy_o = 1'b1;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = bus.addr_a;
    rf_wdata    = bus.data_a;
    sel_b       = 1'b0;
    sel_addr    = bus.addr_a;
    illegal     = 1'b0;

    unique case (state_q)
      StBoot: begin
        state_d = StInit;
        cnt_d   = 5'd1;
      end
      StInit: begin
        rf_we    = 1'b1;
        rf_waddr = cnt_q;
        rf_wdata = WordZeroVal;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        init_busy_o = 1'b0;
        sel_b       = bus.req_b && (!bus.req_a || promote);
        gnt_b       = sel_b;
        gnt_a       = bus.req_a && !sel_b;
        sel_addr    = sel_b ? bus.addr_b : bus.addr_a;
        // RV32E has no x16..x31: grant to unblock the requester, but drop the write
        illegal     = RV32E && sel_addr[4];
        if (sel_b && !illegal) begin
          rf_waddr = bus.addr_b;
          rf_wdata = bus.data_b;
        end
        rf_we = (gnt_a || gnt_b) && !illegal;
        err_d = (gnt_a || gnt_b) && illegal;
        if (init_req_i) begin
          state_d = StInit;
          cnt_d   = 5'd1;
        end
      end
      default: state_d = StBoot;
    endcase
  end

`ifdef IBEX_RF_ARB_FAIRNESS_EN
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  logic [StarveW-1:0] starve_q, starve_d;

  // Counts RUN cycles where B waits; held outside RUN, saturates at StarveLimit
  always_comb begin
    starve_d = starve_q;
    if (state_q == StRun) begin
      if (bus.req_b && !gnt_b) begin
        if (starve_q != StarveW'(StarveLimit)) starve_d = starve_q + StarveW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  assign promote = (starve_q == StarveW'(StarveLimit));
`else
  assign promote = 1'b0;
`endif

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rf_we    = rf_we;
  assign bus.rf_waddr = rf_waddr;
  assign bus.rf_wdata = rf_wdata;

endmodule
